// File: rtl/stop_counter_pkg.sv
// Shared types and constants for the stop_counter block: FSM state encoding
// and the stop-mode selector values.
package stop_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MODE_ANY = 32'd0;
  localparam int unsigned MODE_ALL = 32'd1;

endpackage

// File: rtl/stop_counter_channel.sv
// One saturating channel counter of the stop_counter block: counts enabled
// increments up to the programmed limit and flags when it sits there.
module stop_counter_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             active_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             hit_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear has priority, otherwise step until the limit is reached
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != limit_i)) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign hit_o   = active_i && (count_q == limit_i);

endmodule

// File: rtl/stop_counter.sv
// Multi-channel terminal counter with run/stop FSM and programmable limit.
// Optional one-cycle-lagged snapshot built when STOP_COUNTER_SNAPSHOT_EN is defined.
module stop_counter #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 8,
  parameter int MODE_ALL = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [WIDTH-1:0]        limit,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       hit,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*WIDTH-1:0] snap,
  output logic                    snap_valid
);

  import stop_counter_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic [WIDTH-1:0]  limit_q;
  logic [WIDTH-1:0]  limit_d;
  logic              clear_s;
  logic              stop_s;
  logic              active_s;
  logic              busy_s;
  logic [NUM_CH-1:0] hit_s;

  assign busy_s   = (state_q == RUN);
  assign active_s = (state_q != IDLE);
  assign stop_s   = (MODE_ALL == stop_counter_pkg::MODE_ANY) ? (|hit_s) : (&hit_s);

  // FSM next state; a run starts by latching the limit and clearing every channel
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    clear_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          limit_d = limit;
          clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (stop_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          limit_d = limit;
          clear_s = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and latched limit
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    stop_counter_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clock   (clock),
      .reset   (reset),
      .clear_i (clear_s),
      .en_i    (busy_s && inc[i]),
      .active_i(active_s),
      .limit_i (limit_q),
      .count_o (count[i*WIDTH +: WIDTH]),
      .hit_o   (hit_s[i])
    );
  end

  assign hit  = hit_s;
  assign busy = busy_s;
  assign done = (state_q == DONE);

`ifdef STOP_COUNTER_SNAPSHOT_EN
  logic [NUM_CH*WIDTH-1:0] snap_q;
  logic                    snap_valid_q;

  // Snapshot of counts and run flag, trailing by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_q       <= count;
      snap_valid_q <= busy_s;
    end
  end

  assign snap       = snap_q;
  assign snap_valid = snap_valid_q;
`else
  assign snap       = '0;
  assign snap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stop_counter.sv
// Scoreboard bench for stop_counter: two instances (any-mode 2x8, all-mode 3x3)
// share stimulus; a behavioural model queues expectations, a monitor compares.
module tb_stop_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  inc   = 3'b000;
  logic [7:0]  limit = 8'd0;

  logic [15:0] count_a, snap_a;
  logic [1:0]  hit_a;
  logic        busy_a, done_a, snap_valid_a;
  logic [8:0]  count_b, snap_b;
  logic [2:0]  hit_b;
  logic        busy_b, done_b, snap_valid_b;

  always #5 clock = ~clock;

  stop_counter #(.NUM_CH(2), .WIDTH(8), .MODE_ALL(0)) dut_a (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .inc(inc[1:0]), .limit(limit),
    .count(count_a), .hit(hit_a), .busy(busy_a), .done(done_a),
    .snap(snap_a), .snap_valid(snap_valid_a)
  );

  stop_counter #(.NUM_CH(3), .WIDTH(3), .MODE_ALL(1)) dut_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .inc(inc), .limit(limit[2:0]),
    .count(count_b), .hit(hit_b), .busy(busy_b), .done(done_b),
    .snap(snap_b), .snap_valid(snap_valid_b)
  );

`ifdef STOP_COUNTER_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0][23:0] cnt;
    logic [1:0][2:0]  hit;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0][23:0] snap;
    logic [1:0]       snapv;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: per-instance counts, limit and run/finished flags
  int NCH[2]   = '{2, 3};
  int WID[2]   = '{8, 3};
  int MASK[2]  = '{255, 7};
  bit ALLM[2]  = '{1'b0, 1'b1};
  int m_cnt[2][3];
  int m_lim[2];
  bit m_running[2];
  bit m_finished[2];
  int m_snap[2][3];
  bit m_snapv[2];

  function automatic void model_step(int d, bit r, bit s, bit a, bit [7:0] l, bit [2:0] iv);
    bit any_hit = 1'b0;
    bit all_hit = 1'b1;
    for (int i = 0; i < NCH[d]; i++) begin
      bit h = (m_running[d] || m_finished[d]) && (m_cnt[d][i] == m_lim[d]);
      any_hit = any_hit | h;
      all_hit = all_hit & h;
      m_snap[d][i] = m_cnt[d][i];
    end
    m_snapv[d] = m_running[d];
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[d][i]  = 0;
        m_snap[d][i] = 0;
      end
      m_lim[d] = 0; m_running[d] = 1'b0; m_finished[d] = 1'b0; m_snapv[d] = 1'b0;
    end else if (m_running[d]) begin
      for (int i = 0; i < NCH[d]; i++)
        if (iv[i] && m_cnt[d][i] < m_lim[d]) m_cnt[d][i] = m_cnt[d][i] + 1;
      if (a) m_running[d] = 1'b0;
      else if (ALLM[d] ? all_hit : any_hit) begin
        m_running[d] = 1'b0; m_finished[d] = 1'b1;
      end
    end else if (m_finished[d] && a) begin
      m_finished[d] = 1'b0;
    end else if (s) begin
      m_running[d] = 1'b1; m_finished[d] = 1'b0;
      m_lim[d] = int'(l) & MASK[d];
      for (int i = 0; i < 3; i++) m_cnt[d][i] = 0;
    end
  endfunction

  function automatic void fill_exp(int d, ref exp_t e);
    e.cnt[d] = '0; e.hit[d] = '0; e.snap[d] = '0;
    for (int i = 0; i < NCH[d]; i++) begin
      e.cnt[d] = e.cnt[d] | (24'(m_cnt[d][i]) << (i * WID[d]));
      e.hit[d][i] = (m_running[d] || m_finished[d]) && (m_cnt[d][i] == m_lim[d]);
      if (SNAP_EN) e.snap[d] = e.snap[d] | (24'(m_snap[d][i]) << (i * WID[d]));
    end
    e.busy[d]  = m_running[d];
    e.done[d]  = m_finished[d];
    e.snapv[d] = SNAP_EN ? m_snapv[d] : 1'b0;
  endfunction

  task automatic step(bit r, bit s, bit a, bit [7:0] l, bit [2:0] iv);
    exp_t e;
    @(negedge clock);
    reset = r; start = s; abort = a; limit = l; inc = iv;
    for (int d = 0; d < 2; d++) begin
      model_step(d, r, s, a, l, iv);
      fill_exp(d, e);
    end
    sbq.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every edge the DUTs present a new output set; compare against the queue head
  always @(posedge clock) begin
    #1;
    cyc++;
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("a_count", 32'(count_a), 32'(e.cnt[0][15:0]));
      chk("a_hit",   32'(hit_a),   32'(e.hit[0][1:0]));
      chk("a_busy",  32'(busy_a),  32'(e.busy[0]));
      chk("a_done",  32'(done_a),  32'(e.done[0]));
      chk("a_snap",  32'(snap_a),  32'(e.snap[0][15:0]));
      chk("a_snapv", 32'(snap_valid_a), 32'(e.snapv[0]));
      chk("b_count", 32'(count_b), 32'(e.cnt[1][8:0]));
      chk("b_hit",   32'(hit_b),   32'(e.hit[1]));
      chk("b_busy",  32'(busy_b),  32'(e.busy[1]));
      chk("b_done",  32'(done_b),  32'(e.done[1]));
      chk("b_snap",  32'(snap_b),  32'(e.snap[1][8:0]));
      chk("b_snapv", 32'(snap_valid_b), 32'(e.snapv[1]));
    end
  end

  initial begin
    // reset state
    step(1'b1, 1'b0, 1'b0, 8'd0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 8'd0, 3'b000);
    // any-mode stop at limit 4 on channel 0 only
    step(1'b0, 1'b1, 1'b0, 8'd4, 3'b001);
    repeat (6) step(1'b0, 1'b0, 1'b0, 8'd0, 3'b001);
    step(1'b0, 1'b0, 1'b1, 8'd0, 3'b000);
    // abort at count 2, counts hold in IDLE, abort ignored in IDLE
    step(1'b0, 1'b1, 1'b0, 8'd10, 3'b000);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    step(1'b0, 1'b0, 1'b1, 8'd0, 3'b000);
    repeat (2) step(1'b0, 1'b0, 1'b1, 8'd0, 3'b111);
    // start and abort together while running
    step(1'b0, 1'b1, 1'b0, 8'd9, 3'b111);
    step(1'b0, 1'b1, 1'b1, 8'd9, 3'b111);
    step(1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    // zero limit, then restart from DONE
    step(1'b0, 1'b1, 1'b0, 8'd0, 3'b111);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    step(1'b0, 1'b1, 1'b0, 8'd5, 3'b111);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    // reset mid-run at count 5
    step(1'b0, 1'b1, 1'b1, 8'd20, 3'b000);
    step(1'b0, 1'b1, 1'b0, 8'd20, 3'b111);
    repeat (5) step(1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    step(1'b1, 1'b0, 1'b0, 8'd0, 3'b111);
    step(1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    // all-mode: channels 1 and 2 increment on alternate cycles
    step(1'b0, 1'b1, 1'b0, 8'd3, 3'b000);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b0, 8'd0, {k[0], k[0], 1'b1});
    step(1'b0, 1'b0, 1'b1, 8'd0, 3'b000);
    // saturation at the 3-bit maximum
    step(1'b0, 1'b1, 1'b0, 8'd7, 3'b111);
    repeat (20) step(1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      step(($urandom % 150) == 0, ($urandom % 12) == 0, ($urandom % 25) == 0,
           8'($urandom_range(0, 11)), 3'($urandom));
    end
    for (int k = 0; k < 10 && sbq.size() != 0; k++) @(posedge clock);
    #3;
    n_checks++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stop_counter.md
# stop_counter

Parametrised multi-channel terminal counter with programmable limit, run/stop control and a one-cycle-lagged snapshot of the counts. It is the synthesizable successor of the single-counter stop-at-4 concurrency check. It is used by the MIPS-lite test harness and by the control path as a cycle and event watchdog: increment per channel, stop when the limit is hit, expose `done`.

## Interface
- `NUM_CH`, 2: number of independent channels, ≥1
- `WIDTH`, 8: counter and limit width, ≥1
- `MODE_ALL`, 0: 0 = stop when any channel hits the limit; 1 = stop when all channels hit it
- `clock`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begins a run and samples `limit`
- `abort`  in  1  pulse; cancels a run in progress
- `inc`  in  NUM_CH  per-channel increment request
- `limit`  in  WIDTH  terminal value; sampled only on an accepted `start`
- `count`  out  NUM_CH*WIDTH  current counts, channel 0 in the LSBs
- `hit`  out  NUM_CH  per-channel terminal flag
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `snap`  out  NUM_CH*WIDTH  counts delayed one cycle
- `snap_valid`  out  1  `snap` holds RUN-state counts

## Operation
- States: IDLE, RUN, DONE.
- Reset: state = IDLE. `count` = 0, `limit_q` = 0, `hit` = 0, `busy` = 0, `done` = 0, `snap` = 0, `snap_valid` = 0.
- IDLE:
  - `start` → RUN. Loads `limit_q` ← `limit` and clears all counts.
  - `abort` is ignored.
  - Counts hold.
- RUN:
  - Per channel: `count[i]` += 1 when `inc[i]` is high and `count[i]` != `limit_q`.
  - A channel that has reached `limit_q` saturates; counts never wrap.
  - `abort` → IDLE; counts hold their values.
  - `start` is ignored.
  - `abort` and `start` asserted together → `abort` wins.
- Stop condition: evaluated on the registered `hit` vector (OR of `hit` when `MODE_ALL` = 0, AND of `hit` when `MODE_ALL` = 1). When true, RUN → DONE.
- DONE:
  - Counts and `hit` hold; `done` stays high.
  - `start` restarts the run exactly as from IDLE.
  - `abort` → IDLE.
- `hit[i]` = (state != IDLE) && (`count[i]` == `limit_q`). It is combinational from registers only.
- `limit` = 0: every channel hits immediately on entry to RUN.
- `reset` overrides everything, including during RUN.

## Timing
- Edge k accepts `start` (state = RUN, counts = 0 after edge k).
- With `inc` continuously high and limit L:
  - count = n after edge k+n, for n ≤ L.
  - `hit` is high after edge k+L.
  - `done` is high after edge k+L+1.
  - `busy` is high after edges k through k+L.
- With L = 0: `hit` is high after edge k and `done` after edge k+1.
- `abort` at edge j: `busy` is low after edge j.
- Snapshot: `snap` after edge m equals `count` after edge m−1. `snap_valid` after edge m equals `busy` after edge m−1.
- No combinational path from any input to any output.

## Configuration
- Macro: `STOP_COUNTER_SNAPSHOT_EN`.
- Defined: the snapshot registers exist and `snap`/`snap_valid` behave as above.
- Undefined: no snapshot flops are built. `snap` and `snap_valid` are tied to 0; the ports remain so the interface is unchanged.

## Structure
- Package `stop_counter_pkg` holds:
  - the state enum (IDLE, RUN, DONE) and its 2-bit encoding;
  - the mode constants `MODE_ANY` = 0 and `MODE_ALL` = 1.
- Sub-module `stop_counter_channel`, one instance per channel via generate. It holds one WIDTH-bit saturating counter with ports for clear, enable (= busy && inc), limit and hit.
- The top level holds the FSM, `limit_q`, the stop-condition reduction and the snapshot registers.

## Test plan
- Any-mode stop: NUM_CH = 2, WIDTH = 8, limit = 4, `inc` = 2'b01 held, `start` at edge 0 → count0 = 4 and `hit` = 2'b01 after edge 4; `done` = 1 after edge 5; count1 stays 0.
- All-mode stop: `MODE_ALL` = 1, limit = 3, `inc` = 2'b11 with ch1 idle on alternate cycles → ch0 saturates at 3 while `done` stays 0; `done` rises one cycle after ch1 reaches 3.
- Zero limit and saturation: limit = 0, `start` → `hit` = all ones after edge 0 and `done` after edge 1. Then WIDTH = 3, limit = 7, `inc` held 20 cycles → count stays at 7, never 0.
- Abort and collisions:
  - `abort` at count = 2 → IDLE with counts held at 2.
  - `start` and `abort` together in RUN → IDLE.
  - `start` in DONE → counts cleared and a new run begins.
- Reset mid-run: `reset` at count = 5 → after one edge, all outputs are at their reset values.
- Snapshot: with `STOP_COUNTER_SNAPSHOT_EN`, `snap` trails `count` by exactly one cycle and `snap_valid` trails `busy` by one cycle. Without the macro, `snap` and `snap_valid` remain 0 throughout.
